// File: rtl/boton_evento_arbitro.sv
// Turns debounced button levels into short/long press events and arbitrates them
// round-robin onto one valid/ack channel, flagging events lost to a full slot.
module boton_evento_arbitro #(
    parameter int N_BTN       = 4,
    parameter int LONG_CYCLES = 150000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_BTN-1:0]         btn_db,
    output logic                     evt_valid,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic                     evt_long,
    input  logic                     evt_ack,
    output logic                     evt_overrun
);

    localparam int IW = $clog2(N_BTN);
    localparam int CW = $clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] LONG_M1  = CW'(LONG_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   rr_r;
    logic [N_BTN-1:0] prev_r;
    logic [N_BTN-1:0] long_fired_r;
    logic [N_BTN-1:0] pend_r;
    logic [N_BTN-1:0] pend_long_r;
    logic [CW-1:0]   cnt_r [N_BTN];

    logic [N_BTN-1:0] rise_s;
    logic [N_BTN-1:0] long_hit_s;
    logic [N_BTN-1:0] short_hit_s;
    logic [N_BTN-1:0] lose_s;
    logic             grant_s;
    logic             found_s;
    logic [IW-1:0]    grant_idx_s;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        found_s     = 1'b0;
        grant_idx_s = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            int idx;
            idx = (int'(rr_r) + k) % N_BTN;
            if (!found_s && pend_r[idx]) begin
                found_s     = 1'b1;
                grant_idx_s = IW'(idx);
            end else begin
                found_s     = found_s;
                grant_idx_s = grant_idx_s;
            end
        end
        grant_s = (state_r == ST_IDLE) && found_s;
    end

    // Per-button event detection; a post is lost if the slot stays occupied this cycle.
    always_comb begin
        rise_s      = '0;
        long_hit_s  = '0;
        short_hit_s = '0;
        lose_s      = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rise_s[i]      = btn_db[i] & ~prev_r[i];
            long_hit_s[i]  = btn_db[i] & ~rise_s[i] & ~long_fired_r[i] & (cnt_r[i] == LONG_M1);
            short_hit_s[i] = ~btn_db[i] & prev_r[i] & ~long_fired_r[i];
            if ((long_hit_s[i] | short_hit_s[i]) && pend_r[i]
                && !(grant_s && (grant_idx_s == IW'(i)))) begin
                lose_s[i] = 1'b1;
            end else begin
                lose_s[i] = 1'b0;
            end
        end
    end

    // Hold counters, long-press bookkeeping and the per-button pending slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_r       <= '1;
            long_fired_r <= '1;
            pend_r       <= '0;
            pend_long_r  <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            prev_r <= btn_db;
            for (int i = 0; i < N_BTN; i++) begin
                if (rise_s[i]) begin
                    cnt_r[i]        <= '0;
                    long_fired_r[i] <= 1'b0;
                end else if (btn_db[i]) begin
                    if (cnt_r[i] != LONG_MAX) begin
                        cnt_r[i] <= cnt_r[i] + CW'(1);
                    end
                    if (long_hit_s[i]) begin
                        long_fired_r[i] <= 1'b1;
                    end
                end
                if ((long_hit_s[i] | short_hit_s[i]) && !lose_s[i]) begin
                    pend_r[i]      <= 1'b1;
                    pend_long_r[i] <= long_hit_s[i];
                end else if (grant_s && (grant_idx_s == IW'(i))) begin
                    pend_r[i] <= 1'b0;
                end
            end
        end
    end

    // Offer FSM: grant from IDLE, hold the offer until acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rr_r        <= IW'(N_BTN - 1);
            evt_valid   <= 1'b0;
            evt_id      <= '0;
            evt_long    <= 1'b0;
            evt_overrun <= 1'b0;
        end else begin
            evt_overrun <= |lose_s;
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        evt_id    <= grant_idx_s;
                        evt_long  <= pend_long_r[grant_idx_s];
                        rr_r      <= grant_idx_s;
                        evt_valid <= 1'b1;
                        state_r   <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (evt_ack) begin
                        evt_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    evt_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boton_evento_arbitro.sv
// Directed scenarios plus random presses, compared every cycle against a
// press-duration / event-queue model of the button arbiter.
module tb_boton_evento_arbitro;

    localparam int N = 4;
    localparam int L = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_db;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic         evt_long;
    logic         evt_ack;
    logic         evt_overrun;

    int n_chk  = 0;
    int n_pass = 0;

    // model state: edges held since press, whether a long press is still possible
    int m_hold  [N];
    bit m_last  [N];
    bit m_armed [N];
    bit m_pend  [N];
    bit m_kind  [N];
    bit m_valid, m_long, m_ovr;
    int m_id, m_rr;

    boton_evento_arbitro #(.N_BTN(N), .LONG_CYCLES(L)) dut (
        .clk(clk), .rst(rst), .btn_db(btn_db), .evt_valid(evt_valid),
        .evt_id(evt_id), .evt_long(evt_long), .evt_ack(evt_ack),
        .evt_overrun(evt_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_edge();
        bit np [N];
        int g;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_hold[i] = 0; m_last[i] = 1'b1; m_armed[i] = 1'b0;
                m_pend[i] = 1'b0; m_kind[i] = 1'b0;
            end
            m_valid = 1'b0; m_id = 0; m_long = 1'b0; m_ovr = 1'b0; m_rr = N - 1;
            return;
        end
        g = -1;
        np = m_pend;
        if (!m_valid) begin
            for (int k = 1; k <= N; k++)
                if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
            if (g >= 0) begin
                np[g] = 1'b0; m_valid = 1'b1; m_id = g; m_long = m_kind[g]; m_rr = g;
            end
        end else if (evt_ack) begin
            m_valid = 1'b0;
        end
        m_ovr = 1'b0;
        for (int i = 0; i < N; i++) begin
            bit ev, kind;
            ev = 1'b0; kind = 1'b0;
            if (btn_db[i] && !m_last[i]) begin
                m_hold[i] = 0; m_armed[i] = 1'b1;
            end else if (btn_db[i]) begin
                m_hold[i]++;
                if (m_armed[i] && m_hold[i] == L) begin
                    ev = 1'b1; kind = 1'b1; m_armed[i] = 1'b0;
                end
            end else if (m_last[i] && m_armed[i]) begin
                ev = 1'b1; kind = 1'b0; m_armed[i] = 1'b0;
            end
            if (ev) begin
                if (m_pend[i] && g != i) m_ovr = 1'b1;
                else begin np[i] = 1'b1; m_kind[i] = kind; end
            end
            m_last[i] = btn_db[i];
        end
        m_pend = np;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("evt_valid", 32'(evt_valid), 32'(m_valid));
        chk("evt_id", 32'(evt_id), 32'(m_id));
        chk("evt_long", 32'(evt_long), 32'(m_long));
        chk("evt_overrun", 32'(evt_overrun), 32'(m_ovr));
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic press(input int b, input int len);
        btn_db[b] = 1'b1;
        steps(len);
        btn_db[b] = 1'b0;
    endtask

    task automatic ack_pulse();
        evt_ack = 1'b1;
        step();
        evt_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn_db = '0; evt_ack = 1'b0;
        steps(3);
        rst = 1'b0;
        steps(2);
        // short press of btn 2, offer held without ack
        press(2, 10);
        steps(50);
        ack_pulse();
        steps(10);
        // long press of btn 1
        press(1, 30);
        steps(5);
        ack_pulse();
        steps(5);
        // simultaneous falls, immediate acks
        btn_db[0] = 1'b1; btn_db[1] = 1'b1;
        steps(5);
        btn_db[0] = 1'b0; btn_db[1] = 1'b0;
        evt_ack = 1'b1;
        steps(8);
        btn_db[1] = 1'b1; btn_db[3] = 1'b1;
        evt_ack = 1'b0;
        steps(5);
        btn_db[1] = 1'b0; btn_db[3] = 1'b0;
        evt_ack = 1'b1;
        steps(8);
        evt_ack = 1'b0;
        // overrun on btn 3 while its slot is full
        press(3, 3);
        steps(3);
        press(3, 3);
        steps(2);
        press(2, 3);
        press(3, 3);
        steps(3);
        ack_pulse();
        steps(2);
        ack_pulse();
        steps(2);
        ack_pulse();
        steps(4);
        // button held through reset yields nothing
        rst = 1'b1; btn_db[0] = 1'b1;
        steps(2);
        rst = 1'b0;
        steps(40);
        btn_db[0] = 1'b0;
        steps(5);
        // reset during an offer
        press(2, 4);
        steps(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(10);
        // random presses, acks and occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 11) == 0) btn_db[i] = ~btn_db[i];
            evt_ack = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0; btn_db = '0; evt_ack = 1'b0;
        steps(5);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
